// File: rtl/mango_tpl_sad.sv
// Template-matching SAD scorer: streams features against the mango template ROM and reports one score per frame.
// Optional MANGO_MATCH_THRESH_EN adds a registered match flag (score below MATCH_THRESH).
module mango_tpl_sad #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 8,
    parameter int SCORE_WIDTH  = ADDR_WIDTH + DATA_WIDTH,
    parameter int MATCH_THRESH = 40000
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   feat_valid,
    input  logic [DATA_WIDTH-1:0]  feat_data,
    output logic                   feat_ready,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_rd_data,
    output logic                   busy,
    output logic [SCORE_WIDTH-1:0] score,
    output logic                   score_valid
`ifdef MANGO_MATCH_THRESH_EN
    ,
    output logic                   match
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting features, one ROM address per handshake
    // FLUSH | accumulating the final sample
    // DONE  | publishing score, single score_valid pulse
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = ADDR_WIDTH'(1);
`ifdef MANGO_MATCH_THRESH_EN
    localparam logic [SCORE_WIDTH-1:0] THRESH   = SCORE_WIDTH'(MATCH_THRESH);
`endif

    state_t                 state;
    logic [DATA_WIDTH-1:0]  feat_d;
    logic                   vld_d;
    logic [SCORE_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]  diff;

    // Unsigned |a-b| by ordering the operands before subtracting.
    always_comb begin
        if (feat_d >= rom_rd_data) diff = feat_d - rom_rd_data;
        else                       diff = rom_rd_data - feat_d;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state       <= IDLE;
            rom_addr    <= '0;
            feat_d      <= '0;
            vld_d       <= 1'b0;
            acc         <= '0;
            feat_ready  <= 1'b0;
            busy        <= 1'b0;
            score       <= '0;
            score_valid <= 1'b0;
`ifdef MANGO_MATCH_THRESH_EN
            match       <= 1'b0;
`endif
        end else begin
            score_valid <= 1'b0;
            if (vld_d) acc <= acc + SCORE_WIDTH'(diff);
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        rom_addr   <= '0;
                        acc        <= '0;
                        vld_d      <= 1'b0;
                        feat_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        vld_d      <= 1'b0;
                        feat_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (feat_valid && feat_ready) begin
                        feat_d   <= feat_data;
                        vld_d    <= 1'b1;
                        rom_addr <= rom_addr + ADDR_ONE;
                        if (rom_addr == '1) begin
                            state      <= FLUSH;
                            feat_ready <= 1'b0;
                        end
                    end else begin
                        vld_d <= 1'b0;
                    end
                end
                FLUSH: begin
                    vld_d <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    score       <= acc;
                    score_valid <= 1'b1;
`ifdef MANGO_MATCH_THRESH_EN
                    match       <= (acc < THRESH);
`endif
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    vld_d      <= 1'b0;
                    feat_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mango_tpl_sad.sv
// Directed bench for mango_tpl_sad with a 1-cycle-latency template ROM model.
// Frame vectors come from a table; abort, reset and stray-start cases are hand sequences.
module tb_mango_tpl_sad;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int SW = 19;
    localparam int N  = 2048;

    logic          clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          feat_valid = 1'b0;
    logic [DW-1:0] feat_data = '0;
    logic          feat_ready;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rd_data;
    logic          busy;
    logic [SW-1:0] score;
    logic          score_valid;
`ifdef MANGO_MATCH_THRESH_EN
    logic          match;
`endif

    mango_tpl_sad dut (
        .clk         (clk),
        .tb_rst      (tb_rst),
        .start       (start),
        .abort       (abort),
        .feat_valid  (feat_valid),
        .feat_data   (feat_data),
        .feat_ready  (feat_ready),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .busy        (busy),
        .score       (score),
        .score_valid (score_valid)
`ifdef MANGO_MATCH_THRESH_EN
        ,
        .match       (match)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] tpl [N];
    always @(posedge clk) rom_rd_data <= tpl[rom_addr];

    int sv_pulses = 0;
    always @(posedge clk) if (score_valid === 1'b1) sv_pulses++;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int rom_mode;
        int feat_mode;
        bit gaps;
        int exp_score;
        bit exp_match;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic check(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic load_rom(input int m);
        for (int i = 0; i < N; i++) begin
            case (m)
                0:       tpl[i] = 8'(i);
                1:       tpl[i] = 8'hFF;
                default: tpl[i] = 8'h10;
            endcase
        end
    endtask

    function automatic logic [DW-1:0] feat_of(input int m, input int i);
        case (m)
            0:       return tpl[i];
            1:       return 8'h00;
            2:       return ~tpl[i];
            3:       return 8'h20;
            default: return 8'h05;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", feat_ready, 1);
        check("busy_after_start", busy, 1);
        check("addr_after_start", rom_addr, 0);
    endtask

    task automatic feed(input int fm, input int n, input bit gaps, input bit poke, output int idx);
        int cyc;
        int addr_err;
        bit hs;
        cyc = 0;
        addr_err = 0;
        idx = 0;
        while (idx < n && cyc < 8 * N) begin
            if (rom_addr !== AW'(idx)) addr_err++;
            feat_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            feat_data  = feat_of(fm, idx);
            start      = poke && (idx == 500);
            hs         = feat_valid && feat_ready;
            @(posedge clk);
            if (hs) idx++;
            cyc++;
            @(negedge clk);
        end
        feat_valid = 1'b0;
        start = 1'b0;
        check("addr_track", addr_err, 0);
        check("hs_count", idx, n);
    endtask

    // Entered at the negedge after the last handshake edge (FLUSH cycle).
    task automatic finish_frame(input int exp_score, input bit exp_match, input bit poke);
        check("sv_in_flush", score_valid, 0);
        check("busy_in_flush", busy, 1);
        check("ready_in_flush", feat_ready, 0);
        @(negedge clk);
        check("sv_in_done", score_valid, 0);
        check("busy_in_done", busy, 1);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("score_valid", score_valid, 1);
        check("score", score, exp_score);
        check("busy_after_done", busy, 0);
`ifdef MANGO_MATCH_THRESH_EN
        check("match", match, exp_match);
`endif
        @(negedge clk);
        check("sv_width", score_valid, 0);
        check("score_hold", score, exp_score);
        check("busy_stays_idle", busy, 0);
    endtask

    initial begin
        int got;
        int p0;
        int prev;

        vecs[0] = '{0, 0, 1'b0, 0,      1'b1};
        vecs[1] = '{0, 1, 1'b0, 261120, 1'b0};
        vecs[2] = '{1, 1, 1'b0, 522240, 1'b0};
        vecs[3] = '{0, 0, 1'b1, 0,      1'b1};
        vecs[4] = '{0, 2, 1'b0, 262144, 1'b0};
        vecs[5] = '{2, 3, 1'b0, 32768,  1'b1};
        vecs[6] = '{2, 4, 1'b0, 22528,  1'b1};

        load_rom(0);
        #1;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_feat_ready", feat_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_score", score, 0);
        check("rst_score_valid", score_valid, 0);
`ifdef MANGO_MATCH_THRESH_EN
        check("rst_match", match, 0);
`endif
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            load_rom(vecs[v].rom_mode);
            do_start();
            feed(vecs[v].feat_mode, N, vecs[v].gaps, 1'b0, got);
            finish_frame(vecs[v].exp_score, vecs[v].exp_match, 1'b0);
        end

        // Abort partway through: no score, previous score kept.
        prev = vecs[NV-1].exp_score;
        load_rom(0);
        p0 = sv_pulses;
        do_start();
        feed(1, 1000, 1'b0, 1'b0, got);
        abort = 1'b1;
        feat_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        feat_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", feat_ready, 0);
        check("abort_score_held", score, prev);
        check("abort_sv", score_valid, 0);
        repeat (5) @(negedge clk);
        check("abort_no_pulse", sv_pulses - p0, 0);

        // Reset in the middle of a frame clears every output immediately.
        do_start();
        feed(1, 300, 1'b0, 1'b0, got);
        tb_rst = 1'b1;
        #1;
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_ready", feat_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_score", score, 0);
        check("midrst_sv", score_valid, 0);
`ifdef MANGO_MATCH_THRESH_EN
        check("midrst_match", match, 0);
`endif
        @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);

        // Clean frame with stray start pulses during RUN and DONE.
        p0 = sv_pulses;
        do_start();
        feed(1, N, 1'b0, 1'b1, got);
        finish_frame(261120, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("single_pulse", sv_pulses - p0, 1);
        check("idle_after_stray_start", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
